// File: rtl/reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_pkg
// Description : Shared definitions for the general-purpose register file,
//               also used by the ALU and the control unit.
//               Holds data/address widths, their typedefs, the register
//               reset value and the write-counter ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_data_t  REG_RESET_VAL = '0;
    localparam logic [7:0] WRCOUNT_MAX   = 8'hFF;

endpackage : reg_pkg
`default_nettype wire

// File: rtl/reg_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_port
// Description : One combinational read port of the register file: a mux over
//               the flattened register array, plus an optional write-through
//               comparator that forwards the in-flight write data.
//               Build option: REGFILE_BYPASS_EN enables the forwarding path.
// Ports       : regs     - all register contents, entry i at regs[i]
//               rd_addr  - register index to read
//               rst_n    - active-low reset (forces 0 over the bypass)
//               wr_en    - write enable of the write port
//               wr_addr  - write port destination index
//               wr_data  - write port data
//               rd_data  - read result
// Revision    : 1.0 - initial release
// ============================================================================
module reg_read_port #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               rd_addr,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [DATA_W-1:0]               rd_data
);
    import reg_pkg::*;

`ifdef REGFILE_BYPASS_EN
    logic w_hit;

    assign w_hit = wr_en && (wr_addr == rd_addr);

    always_comb begin
        rd_data = regs[rd_addr];
        // Reset must win over forwarding: the array is already cleared, but
        // the live write data on the bus is not.
        if (!rst_n) begin
            rd_data = DATA_W'(REG_RESET_VAL);
        end else if (w_hit) begin
            rd_data = wr_data;
        end
    end
`else
    // Without forwarding the write-side inputs have no function here.
    logic w_unused;

    assign w_unused = ^{rst_n, wr_en, wr_addr, wr_data};
    assign rd_data  = regs[rd_addr];
`endif

endmodule : reg_read_port
`default_nettype wire

// File: rtl/reg_file_8x8.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_8x8
// Description : Eight-entry, 8-bit general-purpose register file with one
//               synchronous write port, two combinational read ports and a
//               saturating count of committed writes.
//               Build option: REGFILE_BYPASS_EN adds write-through forwarding
//               on both read ports.
// Ports       : CLK          - system clock, rising edge
//               RESET_N      - asynchronous active-low reset
//               IN           - write-back data (ALU result)
//               INADDRESS    - destination register index
//               WRITE        - write enable
//               OUT1ADDRESS  - read port 1 index
//               OUT2ADDRESS  - read port 2 index
//               OUT1         - read port 1 data
//               OUT2         - read port 2 data
//               WRCOUNT      - committed writes since reset, saturates at FF
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_8x8 #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8     // must equal 2**ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic [7:0]        WRCOUNT
);
    import reg_pkg::*;

    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
    logic [7:0]                      r_wrcount;

    // Register array and write counter share one process so a write and its
    // count are always committed together. Register 0 is an ordinary entry.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= DATA_W'(REG_RESET_VAL);
            end
            r_wrcount <= '0;
        end else if (WRITE) begin
            r_regs[INADDRESS] <= IN;
            if (r_wrcount != WRCOUNT_MAX) begin
                r_wrcount <= r_wrcount + 8'd1;
            end
        end
    end

    assign WRCOUNT = r_wrcount;

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_port1 (
        .regs    (r_regs),
        .rd_addr (OUT1ADDRESS),
        .rst_n   (RESET_N),
        .wr_en   (WRITE),
        .wr_addr (INADDRESS),
        .wr_data (IN),
        .rd_data (OUT1)
    );

    reg_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_port2 (
        .regs    (r_regs),
        .rd_addr (OUT2ADDRESS),
        .rst_n   (RESET_N),
        .wr_en   (WRITE),
        .wr_addr (INADDRESS),
        .wr_data (IN),
        .rd_data (OUT2)
    );

`ifndef SYNTHESIS
    // An unknown write enable outside reset has no defined meaning.
    a_write_known : assert property (@(posedge CLK) disable iff (!RESET_N)
                                     !$isunknown(WRITE));
`endif

endmodule : reg_file_8x8
`default_nettype wire
